// File: rtl/count_display_driver.sv
// Converts an 8-bit count to BCD with a sequential double-dabble engine.
// Drives a 4-digit common-anode multiplexed seven-segment display.
module count_display_driver #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        bcd_valid
);

    localparam int             DW       = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    conv_state_t state, state_nxt;

    logic [7:0]  bin_sr;
    logic [7:0]  latched;
    logic [7:0]  last_conv;
    logic        converted;
    logic [2:0]  iter;
    logic [11:0] scratch;
    logic [11:0] scratch_adj;
    logic        start;

    logic [DW-1:0] div;
    logic          wrap;
    logic [1:0]    digit;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic [3:0]    hund, tens, ones;
    logic          blank_h, blank_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // The converted flag forces one conversion after reset even if count matches.
    always_comb start = !converted || (count != last_conv);

    always_comb scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (iter == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr    <= '0;
            latched   <= '0;
            last_conv <= '0;
            converted <= 1'b0;
            iter      <= '0;
            scratch   <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= count;
                        latched <= count;
                        scratch <= '0;
                        iter    <= '0;
                    end
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {scratch_adj, bin_sr} << 1;
                    iter              <= iter + 3'd1;
                end
                DONE: begin
                    // bcd changes only here, so the display never sees a partial result.
                    bcd       <= scratch;
                    last_conv <= latched;
                    converted <= 1'b1;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hund    = bcd[11:8];
    assign tens    = bcd[7:4];
    assign ones    = bcd[3:0];
    assign blank_h = BLANK_LEADING && (hund == 4'd0);
    assign blank_t = BLANK_LEADING && (hund == 4'd0) && (tens == 4'd0);
    assign wrap    = (div == DIV_LAST);
    assign an_nxt  = ~(4'b0001 << digit);

    always_comb begin
        seg_nxt = SEG_OFF;
        case (digit)
            2'd0:    seg_nxt = enc(ones);
            2'd1:    seg_nxt = blank_t ? SEG_OFF : enc(tens);
            2'd2:    seg_nxt = blank_h ? SEG_OFF : enc(hund);
            default: seg_nxt = SEG_OFF;
        endcase
    end

    // an and seg load from the same edge so the anode and pattern switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div   <= '0;
            digit <= '0;
            an    <= 4'b1111;
            seg   <= SEG_OFF;
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            if (wrap) begin
                an    <= an_nxt;
                seg   <= seg_nxt;
                digit <= digit + 2'd1;
            end
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with a fast refresh divider.
module tb_count_display_driver;

    localparam int         RDIV = 4;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk;
    logic        reset;
    logic [7:0]  count;
    logic [3:0]  an,  an1;
    logic [6:0]  seg, seg1;
    logic        dp,  dp1;
    logic [11:0] bcd, bcd1;
    logic        bcd_valid, bcd_valid1;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seen0 [4];
    logic [6:0] seen1 [4];

    count_display_driver #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset), .count(count), .an(an), .seg(seg),
        .dp(dp), .bcd(bcd), .bcd_valid(bcd_valid)
    );

    count_display_driver #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .count(count), .an(an1), .seg(seg1),
        .dp(dp1), .bcd(bcd1), .bcd_valid(bcd_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts falling edges until bcd_valid is seen; 50 means it never came.
    task automatic wait_valid(output int cycles);
        cycles = 50;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bcd_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic scan_capture();
        for (int d = 0; d < 4; d++) begin
            seen0[d] = 'x;
            seen1[d] = 'x;
        end
        for (int i = 0; i < 8 * RDIV; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: seen0[0] = seg;
                4'b1101: seen0[1] = seg;
                4'b1011: seen0[2] = seg;
                4'b0111: seen0[3] = seg;
                default: ;
            endcase
            case (an1)
                4'b1110: seen1[0] = seg1;
                4'b1101: seen1[1] = seg1;
                4'b1011: seen1[2] = seg1;
                4'b0111: seen1[3] = seg1;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        count = 8'd0;
        repeat (3) @(negedge clk);
        n_vec++; if (an !== 4'b1111) begin n_err++; $display("FAIL reset_an got=%b exp=1111", an); end
        n_vec++; if (seg !== SB) begin n_err++; $display("FAIL reset_seg got=%b exp=%b", seg, SB); end
        n_vec++; if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_vec++; if (bcd !== 12'h000) begin n_err++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
        n_vec++; if (bcd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bcd_valid); end
    endtask

    task automatic test_first_conversion();
        int cyc;
        reset = 1'b0;
        wait_valid(cyc);
        n_vec++; if (cyc < 9 || cyc > 10) begin n_err++; $display("FAIL first_latency got=%0d exp=9..10", cyc); end
        n_vec++; if (bcd !== 12'h000) begin n_err++; $display("FAIL first_bcd got=%h exp=000", bcd); end
        scan_capture();
        n_vec++; if (seen0[0] !== S0) begin n_err++; $display("FAIL zero_d0 got=%b exp=%b", seen0[0], S0); end
        n_vec++; if (seen0[1] !== SB) begin n_err++; $display("FAIL zero_d1 got=%b exp=%b", seen0[1], SB); end
        n_vec++; if (seen0[2] !== SB) begin n_err++; $display("FAIL zero_d2 got=%b exp=%b", seen0[2], SB); end
        n_vec++; if (seen0[3] !== SB) begin n_err++; $display("FAIL zero_d3 got=%b exp=%b", seen0[3], SB); end
    endtask

    task automatic test_max();
        int cyc;
        count = 8'd255;
        wait_valid(cyc);
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL max_latency got=%0d exp=10", cyc); end
        n_vec++; if (bcd !== 12'h255) begin n_err++; $display("FAIL max_bcd got=%h exp=255", bcd); end
        scan_capture();
        n_vec++; if (seen0[0] !== S5) begin n_err++; $display("FAIL max_d0 got=%b exp=%b", seen0[0], S5); end
        n_vec++; if (seen0[1] !== S5) begin n_err++; $display("FAIL max_d1 got=%b exp=%b", seen0[1], S5); end
        n_vec++; if (seen0[2] !== S2) begin n_err++; $display("FAIL max_d2 got=%b exp=%b", seen0[2], S2); end
        n_vec++; if (seen0[3] !== SB) begin n_err++; $display("FAIL max_d3 got=%b exp=%b", seen0[3], SB); end
    endtask

    task automatic test_blanking();
        int cyc;
        count = 8'd7;
        wait_valid(cyc);
        n_vec++; if (bcd !== 12'h007) begin n_err++; $display("FAIL b7_bcd got=%h exp=007", bcd); end
        n_vec++; if (bcd1 !== 12'h007) begin n_err++; $display("FAIL b7_bcd_nb got=%h exp=007", bcd1); end
        scan_capture();
        n_vec++; if (seen0[0] !== S7) begin n_err++; $display("FAIL b7_d0 got=%b exp=%b", seen0[0], S7); end
        n_vec++; if (seen0[1] !== SB) begin n_err++; $display("FAIL b7_d1 got=%b exp=%b", seen0[1], SB); end
        n_vec++; if (seen0[2] !== SB) begin n_err++; $display("FAIL b7_d2 got=%b exp=%b", seen0[2], SB); end
        n_vec++; if (seen1[0] !== S7) begin n_err++; $display("FAIL nb7_d0 got=%b exp=%b", seen1[0], S7); end
        n_vec++; if (seen1[1] !== S0) begin n_err++; $display("FAIL nb7_d1 got=%b exp=%b", seen1[1], S0); end
        n_vec++; if (seen1[2] !== S0) begin n_err++; $display("FAIL nb7_d2 got=%b exp=%b", seen1[2], S0); end
        n_vec++; if (seen1[3] !== SB) begin n_err++; $display("FAIL nb7_d3 got=%b exp=%b", seen1[3], SB); end

        count = 8'd42;
        wait_valid(cyc);
        n_vec++; if (bcd !== 12'h042) begin n_err++; $display("FAIL b42_bcd got=%h exp=042", bcd); end
        scan_capture();
        n_vec++; if (seen0[0] !== S2) begin n_err++; $display("FAIL b42_d0 got=%b exp=%b", seen0[0], S2); end
        n_vec++; if (seen0[1] !== S4) begin n_err++; $display("FAIL b42_d1 got=%b exp=%b", seen0[1], S4); end
        n_vec++; if (seen0[2] !== SB) begin n_err++; $display("FAIL b42_d2 got=%b exp=%b", seen0[2], SB); end
    endtask

    // 200 is latched, then count moves to 17 during the 4th shift cycle.
    task automatic test_back_to_back();
        logic [11:0] vals [$];
        logic [11:0] chg  [$];
        int          at   [$];
        logic [11:0] prev;
        prev  = bcd;
        count = 8'd200;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bcd_valid) begin vals.push_back(bcd); at.push_back(i); end
            if (bcd !== prev) begin chg.push_back(bcd); prev = bcd; end
            if (i == 4) count = 8'd17;
        end
        n_vec++; if (vals.size() != 2) begin n_err++; $display("FAIL b2b_pulses got=%0d exp=2", vals.size()); end
        if (vals.size() == 2) begin
            n_vec++; if (vals[0] !== 12'h200) begin n_err++; $display("FAIL b2b_first got=%h exp=200", vals[0]); end
            n_vec++; if (vals[1] !== 12'h017) begin n_err++; $display("FAIL b2b_second got=%h exp=017", vals[1]); end
            n_vec++; if (at[0] != 10 || at[1] != 20) begin n_err++; $display("FAIL b2b_timing got=%0d,%0d exp=10,20", at[0], at[1]); end
        end
        n_vec++; if (chg.size() != 2) begin n_err++; $display("FAIL b2b_changes got=%0d exp=2", chg.size()); end
    endtask

    task automatic test_hold();
        int          pulses;
        int          bad;
        int          run;
        bit          seen_chg;
        logic [3:0]  prev_an;
        pulses   = 0;
        bad      = 0;
        run      = 0;
        seen_chg = 1'b0;
        count    = 8'd99;
        @(negedge clk);
        prev_an = an;
        if (bcd_valid) pulses++;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bcd_valid) pulses++;
            if ($countones(~an) != 1) bad++;
            if (an !== prev_an) begin
                if (seen_chg && run != RDIV) bad++;
                if (an !== {prev_an[2:0], prev_an[3]}) bad++;
                seen_chg = 1'b1;
                run      = 1;
                prev_an  = an;
            end else begin
                run++;
            end
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL hold_pulses got=%0d exp=1", pulses); end
        n_vec++; if (bcd !== 12'h099) begin n_err++; $display("FAIL hold_bcd got=%h exp=099", bcd); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_scan got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_async_reset();
        int cyc;
        count = 8'd123;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++; if (an !== 4'b1111) begin n_err++; $display("FAIL areset_an got=%b exp=1111", an); end
        n_vec++; if (seg !== SB) begin n_err++; $display("FAIL areset_seg got=%b exp=%b", seg, SB); end
        n_vec++; if (bcd !== 12'h000) begin n_err++; $display("FAIL areset_bcd got=%h exp=000", bcd); end
        n_vec++; if (bcd_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got=%b exp=0", bcd_valid); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_valid(cyc);
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL areset_latency got=%0d exp=10", cyc); end
        n_vec++; if (bcd !== 12'h123) begin n_err++; $display("FAIL areset_bcd_after got=%h exp=123", bcd); end
    endtask

    initial begin
        reset = 1'b1;
        count = 8'd0;
        test_reset();
        test_first_conversion();
        test_max();
        test_blanking();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
Consumer of the 8-bit debounced count. It converts the binary count to three BCD digits with a sequential shift-add-3 (double-dabble) engine and drives a 4-digit, common-anode, time-multiplexed seven-segment display. Sits downstream of the debounced counter, between the count bus and the board display pins.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (min 2)
BLANK_LEADING, 1, 1 = blank leading-zero hundreds/tens digits; 0 = always show all three digits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
count  input  8  binary value to display (0..255)
an  output  4  digit anodes, active-low; an[0] = ones, an[3] = leftmost
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low; always 1 (off)
bcd  output  12  {hundreds,tens,ones} currently displayed
bcd_valid  output  1  one-cycle pulse when bcd updates

Behaviour:
- Reset (async, active-high) forces: an=4'b1111, seg=7'b1111111, dp=1, bcd=12'h000, bcd_valid=0, converter FSM=IDLE, scan digit=0, refresh divider=0, last_converted flag cleared (forces a conversion after reset).
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if count != last_converted value, or no conversion since reset: latch count into shift register, clear BCD scratch, iteration counter=0, go to SHIFT.
  - SHIFT: per cycle, add 3 to every scratch nibble >=5, then shift {scratch,bin} left 1. Exactly 8 SHIFT cycles, then DONE.
  - DONE: copy scratch to bcd, record latched count as last_converted, pulse bcd_valid for exactly this cycle, return to IDLE.
  - Latency: count change sampled in IDLE at cycle N -> bcd updated and bcd_valid high at cycle N+9 (1 latch + 8 shift), visible at N+10.
  - count changes during SHIFT/DONE are ignored; the next IDLE cycle detects the mismatch and restarts. The latched value is never corrupted mid-conversion.
  - bcd updates atomically; the display never shows a partial conversion.
- Scan:
  - Free-running divider counts 0..REFRESH_DIV-1. On wrap, scan digit advances 0->1->2->3->0.
  - an/seg are registered: one output changes per divider wrap, both from the same edge, so there is no ghosting glitch.
  - Digit 3: an[3]=0 with seg=7'b1111111 (blank). The anode is kept active for uniform duty cycle.
  - Digits 0..2 show ones, tens and hundreds.
  - With BLANK_LEADING=1: hundreds blank if 0; tens blank if hundreds=0 and tens=0. Ones is always shown (0 displays as "0").
  - Blanked digit: seg=7'b1111111; the anode is still driven.
- Encoding (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble >9 is unreachable; decode to blank.
- Exactly one an bit is low at any time after the first divider wrap post-reset.
- Reset mid-conversion aborts cleanly. After release, the current count is converted from scratch.

Test Plan:
- Reset, then count=8'd0, REFRESH_DIV=4 -> bcd_valid pulse 9-10 cycles after reset release with bcd=12'h000. Digit 0 seg=1000000, digits 1,2,3 blank.
- count=8'd255 -> bcd=12'h255. Scanning shows seg 0010010 on an=1110, 0010010 on an=1101, 0100100 on an=1011, blank on an=0111.
- count=8'd7, then 8'd42 -> bcd=12'h007 then 12'h042. Hundreds blank both times; tens blank for 7 only. Rerun with BLANK_LEADING=0 -> 12'h007 shows 0,0,7.
- count changes 200->17 on the 4th SHIFT cycle -> first bcd_valid carries 12'h200. A second conversion follows immediately with 12'h017. No intermediate bcd value appears.
- Hold count constant 1000 cycles -> exactly one bcd_valid pulse. an cycles 1110,1101,1011,0111 every 4 cycles with exactly one bit low.
- Assert reset asynchronously mid-SHIFT -> outputs go to reset values without a clock edge. After release, the current count is reconverted correctly.
